// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding and defaults for the HI/LO divide sequencer
package hilo_pkg;

   localparam int DEFAULT_WIDTH   = 32;
   localparam int DEFAULT_TIMEOUT = 64;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      COMMIT,
      ZERO,
      TOUT
   } state_t;

endpackage

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - divide sequencer owning architectural HI/LO
// Latches operands, pulses the divider start, waits for completion with a timeout, commits HI/LO.
module hilo_ctrl
   import hilo_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_hi,
   input  logic [WIDTH-1:0] div_lo,
   input  logic             div_zero,
   input  logic             div_fim,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] mt_data,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div0_exc,
   output logic             timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             div_start_q, div_start_d;
   logic             done_q, done_d;
   logic             div0_exc_q, div0_exc_d;
   logic             timeout_err_q, timeout_err_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         div_start_q   <= 1'b0;
         done_q        <= 1'b0;
         div0_exc_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         a_q           <= a_d;
         b_q           <= b_d;
         div_start_q   <= div_start_d;
         done_q        <= done_d;
         div0_exc_q    <= div0_exc_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Pulse outputs are registered, so each is raised on the edge that enters its state.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      a_d           = a_q;
      b_d           = b_q;
      div_start_d   = 1'b0;
      done_d        = 1'b0;
      div0_exc_d    = 1'b0;
      timeout_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (mt_hi) hi_d = mt_data;
            if (mt_lo) lo_d = mt_data;
            if (op_start) begin
               a_d = a_in;
               b_d = b_in;
               if (b_in == '0) begin
                  state_d    = ZERO;
                  div0_exc_d = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  div_start_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A completion in the final counted cycle still wins over the timeout.
            if (div_fim) begin
               if (div_zero) begin
                  state_d    = ZERO;
                  div0_exc_d = 1'b1;
               end else begin
                  hi_d    = div_hi;
                  lo_d    = div_lo;
                  state_d = COMMIT;
                  done_d  = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = TOUT;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         COMMIT, ZERO, TOUT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign div_start   = div_start_q;
   assign div_a       = a_q;
   assign div_b       = b_q;
   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign div0_exc    = div0_exc_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - self-checking bench for hilo_ctrl against a timeline reference model
module tb_hilo_ctrl;
   import hilo_pkg::*;

   localparam int W  = 32;
   localparam int TO = 64;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         op_start = 1'b0;
   logic [W-1:0] a_in = '0, b_in = '0;
   logic         div_start;
   logic [W-1:0] div_a, div_b;
   logic [W-1:0] div_hi, div_lo;
   logic         div_zero, div_fim;
   logic         mt_hi = 1'b0, mt_lo = 1'b0;
   logic [W-1:0] mt_data = '0;
   logic [W-1:0] hi_out, lo_out;
   logic         busy, done, div0_exc, timeout_err;

   always #5 clk = ~clk;

   hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .op_start(op_start), .a_in(a_in), .b_in(b_in),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_hi(div_hi), .div_lo(div_lo), .div_zero(div_zero), .div_fim(div_fim),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done),
      .div0_exc(div0_exc), .timeout_err(timeout_err)
   );

   // Divider stand-in: fim is high exactly lat cycles after the div_start cycle (lat=0 never answers).
   int           lat_cfg = 33;
   logic         zero_cfg = 1'b0;
   logic         man_fim = 1'b0;
   logic [W-1:0] m_hi = '0, m_lo = '0;
   int           dcnt = 0;

   always @(posedge clk or negedge reset)
      if (!reset)         dcnt <= 0;
      else if (div_start) dcnt <= lat_cfg;
      else if (dcnt > 0)  dcnt <= dcnt - 1;

   assign div_fim  = (dcnt == 1) | man_fim;
   assign div_zero = zero_cfg & (dcnt == 1);
   assign div_hi   = m_hi;
   assign div_lo   = m_lo;

   int n_pass = 0, n_fail = 0, n_total = 0;
   logic [W-1:0] exp_hi = '0, exp_lo = '0, exp_a = '0, exp_b = '0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_cycle(input string tag, input bit ds, bz, dn, ex, te);
      check({tag, " ctrl"}, 128'({div_start, busy, done, div0_exc, timeout_err}),
            128'({ds, bz, dn, ex, te}));
      check({tag, " data"}, {hi_out, lo_out, div_a, div_b}, {exp_hi, exp_lo, exp_a, exp_b});
   endtask

   // One divide request with its whole expected timeline, cycle 1 being the cycle after op_start.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input bit dz, input bit wh, input bit wl,
                         input logic [W-1:0] wd, input bit noise);
      int  kind, k, last;
      logic [W-1:0] q, r;
      k = 0;
      if (b == '0)                  begin kind = 0; last = 2; end
      else if (lat >= 1 && lat <= TO) begin k = 1 + lat; kind = dz ? 2 : 1; last = k + 2; end
      else                          begin kind = 3; last = TO + 3; end
      q = (b != '0) ? a / b : '0;
      r = (b != '0) ? a % b : '0;
      lat_cfg  = lat;
      zero_cfg = dz;
      m_hi     = r;
      m_lo     = q;

      @(negedge clk);
      a_in = a; b_in = b; op_start = 1'b1;
      mt_hi = wh; mt_lo = wl; mt_data = wd;
      @(posedge clk);
      #1;
      op_start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      if (wh) exp_hi = wd;
      if (wl) exp_lo = wd;
      exp_a = a;
      exp_b = b;

      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (kind == 1 && n == k + 1) begin
            exp_hi = r;
            exp_lo = q;
         end
         check_cycle($sformatf("%s c%0d", name, n),
                     (b != '0) && n == 1,
                     n < last,
                     kind == 1 && n == k + 1,
                     (kind == 0 && n == 1) || (kind == 2 && n == k + 1),
                     kind == 3 && n == TO + 2);
         if (noise && n < last) begin
            if (n == 3 || $urandom_range(0, 7) == 0) begin
               op_start = 1'b1; a_in = $urandom; b_in = $urandom;
            end
            if (n == 4 || $urandom_range(0, 7) == 0) begin
               mt_lo = 1'b1; mt_hi = $urandom_range(0, 1) == 1; mt_data = $urandom;
            end
         end
         @(posedge clk);
         #1;
         op_start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
      end
   endtask

   task automatic idle_mt(input string name, input bit wh, input bit wl, input logic [W-1:0] wd);
      @(negedge clk);
      mt_hi = wh; mt_lo = wl; mt_data = wd;
      @(posedge clk);
      #1;
      mt_hi = 1'b0; mt_lo = 1'b0;
      if (wh) exp_hi = wd;
      if (wl) exp_lo = wd;
      @(negedge clk);
      check_cycle(name, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      run_op("div100_7", 32'd100, 32'd7, 33, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("div100_7 hi", 128'(hi_out), 128'(32'd2));
      check("div100_7 lo", 128'(lo_out), 128'(32'd14));
      run_op("div5_0", 32'd5, 32'd0, 33, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      run_op("timeout", 32'd77, 32'd3, 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      idle_mt("mthi", 1'b1, 1'b0, 32'hDEADBEEF);
      idle_mt("mtlo", 1'b0, 1'b1, 32'h12345678);
      run_op("fim_last", 32'd1000, 32'd9, TO, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      run_op("fim_late", 32'd1000, 32'd9, TO + 1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      run_op("fim_fast", 32'hFFFF_FFFF, 32'd16, 1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      run_op("defzero", 32'd50, 32'd5, 10, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      run_op("mt_op", 32'd81, 32'd9, 5, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);
      run_op("mt_op0", 32'd81, 32'd0, 5, 1'b0, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0);

      // Asynchronous reset while the divider is still outstanding.
      @(negedge clk);
      lat_cfg = 0; m_hi = 32'h1111_2222; m_lo = 32'h3333_4444;
      a_in = 32'd9; b_in = 32'd3; op_start = 1'b1;
      @(posedge clk);
      #1 op_start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      exp_hi = '0; exp_lo = '0; exp_a = '0; exp_b = '0;
      check_cycle("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      man_fim = 1'b1;
      @(posedge clk);
      #1 man_fim = 1'b0;
      @(negedge clk);
      check_cycle("fim_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a, b, wd;
         int lat, sel;
         a   = $urandom;
         b   = ($urandom_range(0, 5) == 0) ? '0 :
               ($urandom_range(0, 1) == 1) ? W'($urandom_range(1, 1000)) : W'($urandom);
         sel = $urandom_range(0, 9);
         lat = (sel == 0) ? 0 : (sel == 1) ? TO : (sel == 2) ? 1 : (sel == 3) ? TO + 1 :
               $urandom_range(2, 40);
         wd  = $urandom;
         run_op($sformatf("rnd%0d", i), a, b, lat, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, wd, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
